// File: rtl/qclk_sched.sv
// Timed-command scheduler: queues (timestamp, payload) commands in order and
// releases each payload as a one-cycle pulse once qclk reaches its timestamp.
module qclk_sched #(
    parameter int WIDTH      = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       qclk_val,
    input  logic                   qclk_load,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       cmd_time,
    input  logic [DATA_WIDTH-1:0]  cmd_data,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_late,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0]      time_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  push;
    logic                  pop;
    logic [WIDTH-1:0]      head_time;
    logic [DATA_WIDTH-1:0] head_data;
    logic [WIDTH-1:0]      diff;

    // Handshake: a command transfers on any cycle where cmd_valid && cmd_ready;
    // cmd_ready looks only at the registered count, so a same-cycle pop never
    // frees a slot for that cycle's push. flush discards a concurrent push.
    assign cmd_ready = (count < CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready && !flush;

    assign head_time = time_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Modulo difference read as two's complement: zero is on time, negative is late.
    assign diff = head_time - qclk_val;
    assign pop  = !flush && !qclk_load && (count != '0)
                  && ((diff == '0) || diff[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (push) begin
            time_mem[wr_ptr] <= cmd_time;
            data_mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_late  <= 1'b0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_data <= head_data;
                out_late <= (diff != '0);
            end else begin
                out_late <= 1'b0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule
